// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default counter width / multiply-divide timeout and the operand-match helper.
package hazard_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int MD_MAX_DEF = 64;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_t;

   // True when an ID source operand is actually read and names the EX destination.
   function automatic logic src_hit(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath (master) and the hazard controller
// (slave): hazard sources flow in, write enables and bubble requests flow out.
interface hazard_ctrl_if;
   logic [4:0] id_rs_addr;
   logic [4:0] id_rt_addr;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_jump;
   logic       ex_MemRead;
   logic [4:0] ex_write_addr;
   logic       ex_branch_taken;
   logic       ex_muldiv_start;
   logic       muldiv_done;
   logic       pc_wr_en;
   logic       if_id_wr_en;
   logic       id_ex_wr_en;
   logic       if_id_flush;
   logic       id_ex_flush;

   modport master (
      output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_jump,
             ex_MemRead, ex_write_addr, ex_branch_taken, ex_muldiv_start,
             muldiv_done,
      input  pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_flush
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_jump,
             ex_MemRead, ex_write_addr, ex_branch_taken, ex_muldiv_start,
             muldiv_done,
      output pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_flush
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping; synchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count one per cycle with inc set, stopping at the top value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Produces same-cycle (Mealy) write-enable and
// bubble controls from the current hazard inputs plus a small FSM that tracks
// an outstanding multiply/divide. Priority: MD stall, branch flush, load-use
// stall, jump flush. A watchdog bounds the MD wait and raises a sticky error.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int MD_MAX = MD_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             md_error
);

   // md_cnt only has to reach MD_MAX-1, so clog2(MD_MAX) bits are enough.
   localparam int MD_CNT_W = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;
   localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_MAX - 1);

   md_state_t           state;
   logic [MD_CNT_W-1:0] md_cnt;

   logic md_timeout;
   logic md_stall;
   logic load_use;

   logic pc_wr_en;
   logic if_id_wr_en;
   logic id_ex_wr_en;
   logic if_id_flush;
   logic id_ex_flush;

   // Hazard detection: MD wait / watchdog expiry and the load-use match.
   always_comb begin
      md_timeout = (state == MD_WAIT) && !hz.muldiv_done && (md_cnt == MD_LAST);
      md_stall   = ((state == MD_WAIT) && !hz.muldiv_done && !md_timeout) ||
                   ((state == RUN) && hz.ex_muldiv_start && !hz.muldiv_done);
      load_use   = hz.ex_MemRead && (hz.ex_write_addr != 5'd0) &&
                   (src_hit(hz.id_uses_rs, hz.id_rs_addr, hz.ex_write_addr) ||
                    src_hit(hz.id_uses_rt, hz.id_rt_addr, hz.ex_write_addr));
   end

   // Prioritised control outputs; reset forces the free-running defaults.
   always_comb begin
      pc_wr_en    = 1'b1;
      if_id_wr_en = 1'b1;
      id_ex_wr_en = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         if (md_stall) begin
            pc_wr_en    = 1'b0;
            if_id_wr_en = 1'b0;
            id_ex_wr_en = 1'b0;
         end else if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into EX; a coincident jump is
            // dropped here and seen again next cycle from the held IF/ID.
            pc_wr_en    = 1'b0;
            if_id_wr_en = 1'b0;
            id_ex_flush = 1'b1;
         end else if (hz.id_jump) begin
            if_id_flush = 1'b1;
         end
      end
   end

   assign hz.pc_wr_en    = pc_wr_en;
   assign hz.if_id_wr_en = if_id_wr_en;
   assign hz.id_ex_wr_en = id_ex_wr_en;
   assign hz.if_id_flush = if_id_flush;
   assign hz.id_ex_flush = id_ex_flush;

   // MD tracking FSM with wait-cycle watchdog and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= RUN;
         md_cnt   <= '0;
         md_error <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hz.ex_muldiv_start && !hz.muldiv_done) begin
                  state  <= MD_WAIT;
                  md_cnt <= '0;
               end
            end
            MD_WAIT: begin
               if (hz.muldiv_done) begin
                  state  <= RUN;
                  md_cnt <= '0;
               end else if (md_timeout) begin
                  state    <= RUN;
                  md_cnt   <= '0;
                  md_error <= 1'b1;
               end else begin
                  md_cnt <= md_cnt + 1'b1;
               end
            end
            default: begin
               state  <= RUN;
               md_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!pc_wr_en),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share one stimulus stream:
// "a" uses the default widths, "b" uses CNT_W=4 / MD_MAX=4 for the watchdog
// and saturation cases. Expected values go into a scoreboard queue as each
// step is driven and are popped and compared once the outputs have settled.
module tb_hazard_ctrl;

   localparam int K_CTL   = 0;
   localparam int K_STALL = 1;
   localparam int K_FLUSH = 2;
   localparam int K_ERR   = 3;

   typedef struct {
      string       tag;
      int          kind;
      bit          on_b;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   logic [4:0] id_rs_addr, id_rt_addr, ex_write_addr;
   logic       id_uses_rs, id_uses_rt, id_jump, ex_MemRead;
   logic       ex_branch_taken, ex_muldiv_start, muldiv_done;

   logic [15:0] stall_a, flush_a;
   logic [3:0]  stall_b, flush_b;
   logic        err_a, err_b;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_if ia ();
   hazard_ctrl_if ib ();

   assign ia.id_rs_addr      = id_rs_addr;
   assign ia.id_rt_addr      = id_rt_addr;
   assign ia.id_uses_rs      = id_uses_rs;
   assign ia.id_uses_rt      = id_uses_rt;
   assign ia.id_jump         = id_jump;
   assign ia.ex_MemRead      = ex_MemRead;
   assign ia.ex_write_addr   = ex_write_addr;
   assign ia.ex_branch_taken = ex_branch_taken;
   assign ia.ex_muldiv_start = ex_muldiv_start;
   assign ia.muldiv_done     = muldiv_done;

   assign ib.id_rs_addr      = id_rs_addr;
   assign ib.id_rt_addr      = id_rt_addr;
   assign ib.id_uses_rs      = id_uses_rs;
   assign ib.id_uses_rt      = id_uses_rt;
   assign ib.id_jump         = id_jump;
   assign ib.ex_MemRead      = ex_MemRead;
   assign ib.ex_write_addr   = ex_write_addr;
   assign ib.ex_branch_taken = ex_branch_taken;
   assign ib.ex_muldiv_start = ex_muldiv_start;
   assign ib.muldiv_done     = muldiv_done;

   hazard_ctrl #(.CNT_W(16), .MD_MAX(64)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .hz        (ia),
      .stall_cnt (stall_a),
      .flush_cnt (flush_a),
      .md_error  (err_a)
   );

   hazard_ctrl #(.CNT_W(4), .MD_MAX(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .hz        (ib),
      .stall_cnt (stall_b),
      .flush_cnt (flush_b),
      .md_error  (err_b)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] obs(input int kind, input bit on_b);
      logic [31:0] r;
      r = 32'hDEAD_BEEF;
      case (kind)
         K_CTL:   r = on_b ? {27'd0, ib.pc_wr_en, ib.if_id_wr_en, ib.id_ex_wr_en,
                                     ib.if_id_flush, ib.id_ex_flush}
                           : {27'd0, ia.pc_wr_en, ia.if_id_wr_en, ia.id_ex_wr_en,
                                     ia.if_id_flush, ia.id_ex_flush};
         K_STALL: r = on_b ? {28'd0, stall_b} : {16'd0, stall_a};
         K_FLUSH: r = on_b ? {28'd0, flush_b} : {16'd0, flush_a};
         K_ERR:   r = on_b ? {31'd0, err_b} : {31'd0, err_a};
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   task automatic expect_v(input string tag, input int kind, input bit on_b,
                           input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.on_b = on_b;
      e.val  = val;
      sb.push_back(e);
   endtask

   // Control vector order: {pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_flush}
   task automatic ctl2(input string tag, input logic [4:0] v);
      expect_v({tag, "_a"}, K_CTL, 1'b0, {27'd0, v});
      expect_v({tag, "_b"}, K_CTL, 1'b1, {27'd0, v});
   endtask

   task automatic settle_check();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.kind, e.on_b);
         checks++;
         assert (o === e.val)
         else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic idle();
      id_rs_addr      = 5'd0;
      id_rt_addr      = 5'd0;
      ex_write_addr   = 5'd0;
      id_uses_rs      = 1'b0;
      id_uses_rt      = 1'b0;
      id_jump         = 1'b0;
      ex_MemRead      = 1'b0;
      ex_branch_taken = 1'b0;
      ex_muldiv_start = 1'b0;
      muldiv_done     = 1'b0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic load_use(input logic [4:0] r);
      ex_MemRead    = 1'b1;
      ex_write_addr = r;
      id_rs_addr    = r;
      id_uses_rs    = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      repeat (2) @(posedge clk);

      // Reset dominates every hazard input
      next(); ex_branch_taken = 1'b1; id_jump = 1'b1; load_use(5'd8); ex_muldiv_start = 1'b1;
      ctl2("rst_dflt", 5'b11100);
      expect_v("rst_stall_a", K_STALL, 1'b0, 0);
      expect_v("rst_flush_a", K_FLUSH, 1'b0, 0);
      expect_v("rst_err_a",   K_ERR,   1'b0, 0);
      expect_v("rst_stall_b", K_STALL, 1'b1, 0);
      settle_check();

      // Load-use on rs = r8
      next(); reset = 1'b1; load_use(5'd8);
      ctl2("ld_use", 5'b00101);
      expect_v("ld_use_cnt0", K_STALL, 1'b0, 0);
      settle_check();
      next();
      ctl2("ld_use_rel", 5'b11100);
      expect_v("ld_use_cnt1_a", K_STALL, 1'b0, 1);
      expect_v("ld_use_cnt1_b", K_STALL, 1'b1, 1);
      settle_check();

      // Register 0 never stalls
      next(); ex_MemRead = 1'b1; ex_write_addr = 5'd0; id_rs_addr = 5'd0; id_uses_rs = 1'b1;
      ctl2("r0_no_stall", 5'b11100);
      settle_check();

      // rt match gated by id_uses_rt
      next(); ex_MemRead = 1'b1; ex_write_addr = 5'd5; id_rt_addr = 5'd5;
      ctl2("rt_unused", 5'b11100);
      settle_check();
      next(); ex_MemRead = 1'b1; ex_write_addr = 5'd5; id_rt_addr = 5'd5; id_uses_rt = 1'b1;
      ctl2("ld_use_rt", 5'b00101);
      expect_v("r0_not_counted", K_STALL, 1'b0, 1);
      settle_check();
      next();
      ctl2("idle1", 5'b11100);
      expect_v("stall2", K_STALL, 1'b0, 2);
      expect_v("flush0", K_FLUSH, 1'b0, 0);
      settle_check();

      // Branch + jump together
      next(); ex_branch_taken = 1'b1; id_jump = 1'b1;
      ctl2("br_jmp", 5'b11111);
      settle_check();

      // Jump alone
      next(); id_jump = 1'b1;
      ctl2("jmp", 5'b11110);
      expect_v("flush1_a", K_FLUSH, 1'b0, 1);
      expect_v("flush1_b", K_FLUSH, 1'b1, 1);
      settle_check();

      // Jump suppressed by load-use
      next(); id_jump = 1'b1; load_use(5'd8);
      ctl2("jmp_ld_use", 5'b00101);
      expect_v("flush2", K_FLUSH, 1'b0, 2);
      settle_check();

      // Branch beats load-use
      next(); ex_branch_taken = 1'b1; load_use(5'd8);
      ctl2("br_ld_use", 5'b11111);
      expect_v("stall3", K_STALL, 1'b0, 3);
      expect_v("flush2b", K_FLUSH, 1'b0, 2);
      settle_check();

      // MD start with done in the same cycle: no stall
      next(); ex_muldiv_start = 1'b1; muldiv_done = 1'b1;
      ctl2("md_same_done", 5'b11100);
      expect_v("flush3", K_FLUSH, 1'b0, 3);
      settle_check();
      next();
      ctl2("idle2", 5'b11100);
      expect_v("stall3b", K_STALL, 1'b0, 3);
      settle_check();

      // MD stall on instance a: start, 4 waits (branch ignored), done after 5
      next(); ex_muldiv_start = 1'b1;
      expect_v("md_start", K_CTL, 1'b0, 32'b00000);
      settle_check();
      for (int k = 1; k <= 4; k++) begin
         next();
         if (k == 2) ex_branch_taken = 1'b1;
         expect_v($sformatf("md_wait%0d", k), K_CTL, 1'b0, 32'b00000);
         settle_check();
      end
      next(); muldiv_done = 1'b1;
      expect_v("md_done", K_CTL, 1'b0, 32'b11100);
      settle_check();
      next();
      expect_v("md_idle", K_CTL, 1'b0, 32'b11100);
      expect_v("md_stall_cnt", K_STALL, 1'b0, 8);
      expect_v("md_flush_cnt", K_FLUSH, 1'b0, 3);
      expect_v("md_no_err",    K_ERR,   1'b0, 0);
      settle_check();

      // Reset clears everything on both instances
      next(); reset = 1'b0; ex_muldiv_start = 1'b1;
      ctl2("rst_dflt2", 5'b11100);
      settle_check();
      next(); reset = 1'b1;
      ctl2("post_rst", 5'b11100);
      expect_v("rst2_stall_a", K_STALL, 1'b0, 0);
      expect_v("rst2_stall_b", K_STALL, 1'b1, 0);
      expect_v("rst2_flush_b", K_FLUSH, 1'b1, 0);
      expect_v("rst2_err_b",   K_ERR,   1'b1, 0);
      settle_check();

      // Watchdog on instance b (MD_MAX=4): 4 stall cycles then release
      next(); ex_muldiv_start = 1'b1;
      expect_v("to_start", K_CTL, 1'b1, 32'b00000);
      settle_check();
      for (int k = 1; k <= 3; k++) begin
         next();
         expect_v($sformatf("to_wait%0d", k), K_CTL, 1'b1, 32'b00000);
         settle_check();
      end
      next();
      expect_v("to_release", K_CTL, 1'b1, 32'b11100);
      expect_v("to_err_pre", K_ERR, 1'b1, 0);
      settle_check();
      next();
      expect_v("to_idle",  K_CTL,   1'b1, 32'b11100);
      expect_v("to_err",   K_ERR,   1'b1, 1);
      expect_v("to_stall", K_STALL, 1'b1, 4);
      settle_check();
      // b back in RUN sees load-use; a is still waiting on its MD op
      next(); load_use(5'd8);
      expect_v("to_run_ld_use", K_CTL, 1'b1, 32'b00101);
      expect_v("a_still_wait",  K_CTL, 1'b0, 32'b00000);
      settle_check();

      // Reset mid-wait on a, and clears b's sticky error
      next(); reset = 1'b0;
      ctl2("rst_dflt3", 5'b11100);
      settle_check();
      next(); reset = 1'b1; load_use(5'd8);
      ctl2("rst_abort_md", 5'b00101);
      expect_v("rst3_err_a",   K_ERR,   1'b0, 0);
      expect_v("rst3_err_b",   K_ERR,   1'b1, 0);
      expect_v("rst3_stall_b", K_STALL, 1'b1, 0);
      expect_v("rst3_flush_b", K_FLUSH, 1'b1, 0);
      settle_check();

      // Saturation on b: 15 stall cycles reach 15, one more holds
      repeat (14) begin
         next(); load_use(5'd8);
      end
      next();
      expect_v("sat_reach", K_STALL, 1'b1, 15);
      settle_check();
      next(); load_use(5'd8);
      expect_v("sat_stall_ctl", K_CTL, 1'b1, 32'b00101);
      settle_check();
      next();
      expect_v("sat_hold",  K_STALL, 1'b1, 15);
      expect_v("wide_cnt",  K_STALL, 1'b0, 16);
      settle_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 Parameter MD_MAX, default 64, maximum MD_WAIT cycles before the timeout fires.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-005 id_rs_addr, id_rt_addr  in  5 each  ID-stage source register addresses.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 id_jump  in  1  jump resolved in ID.
REQ-008 ex_MemRead  in  1  EX-stage instruction is a load.
REQ-009 ex_write_addr  in  5  EX-stage destination register.
REQ-010 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-011 ex_muldiv_start  in  1  one-cycle pulse: a mul/div instruction is in EX this cycle.
REQ-012 muldiv_done  in  1  multiplier/divider result valid this cycle.
REQ-013 pc_wr_en, if_id_wr_en, id_ex_wr_en  out  1 each  pipeline write enables.
REQ-014 if_id_flush, id_ex_flush  out  1 each  bubble inserts, honoured by the registers only when the matching wr_en=1.
REQ-015 stall_cnt  out  CNT_W  saturating count of cycles with pc_wr_en=0.
REQ-016 flush_cnt  out  CNT_W  saturating count of cycles with if_id_flush=1.
REQ-017 md_error  out  1  sticky flag: MD_WAIT exceeded MD_MAX cycles.

Function
REQ-018 Control outputs SHALL be combinational (Mealy) from state and current inputs, giving zero-cycle hazard response.
REQ-019 FSM SHALL have two states: RUN and MD_WAIT.
REQ-020 Defaults: all wr_en=1, all flush=0.
REQ-021 Priority, highest first: MD stall, branch flush, load-use stall, jump flush.
REQ-022 MD stall is active in MD_WAIT with muldiv_done=0, or in RUN with ex_muldiv_start=1 and muldiv_done=0.
REQ-023 During an MD stall: pc_wr_en=if_id_wr_en=id_ex_wr_en=0, both flushes=0.
REQ-024 RUN->MD_WAIT when ex_muldiv_start=1 and muldiv_done=0.
REQ-025 MD_WAIT->RUN when muldiv_done=1; all enables =1 in that same cycle.
REQ-026 A start pulse with muldiv_done=1 in the same cycle SHALL cause no stall.
REQ-027 md_cnt SHALL increment each MD_WAIT cycle.
REQ-028 When md_cnt reaches MD_MAX-1 without done: set md_error, return to RUN next cycle, release the stall.
REQ-029 Branch flush (ex_branch_taken=1): if_id_flush=1, id_ex_flush=1, all wr_en=1.
REQ-030 Load-use condition: ex_MemRead=1 and ex_write_addr!=0 and ((id_uses_rs and id_rs_addr==ex_write_addr) or (id_uses_rt and id_rt_addr==ex_write_addr)).
REQ-031 On load-use: pc_wr_en=0, if_id_wr_en=0, id_ex_wr_en=1, id_ex_flush=1, if_id_flush=0; the condition clears naturally next cycle.
REQ-032 Jump flush (id_jump=1, no higher-priority event): if_id_flush=1 only.
REQ-033 A jump coinciding with load-use SHALL be suppressed (the jump is re-seen next cycle).
REQ-034 Register 0 SHALL never trigger load-use.
REQ-035 Counters SHALL saturate at all-ones and never wrap.
REQ-036 Counters update at the edge following the counted cycle.

Reset
REQ-037 On reset==0: state=RUN, md_cnt=0, stall_cnt=0, flush_cnt=0, md_error=0.
REQ-038 While reset==0, outputs SHALL be all wr_en=1 and all flush=0, regardless of other inputs.
REQ-039 Reset asserted mid-MD_WAIT SHALL abort the wait with no md_error.

Structure
REQ-040 A shared package hazard_pkg SHALL hold the state enum (RUN, MD_WAIT) and the CNT_W and MD_MAX defaults.
REQ-041 One sub-module sat_counter (parameterised width, inc, reset) SHALL be instantiated twice, for stall_cnt and flush_cnt.

Verification
REQ-042 Load-use: ex_MemRead=1, ex_write_addr=8, id_rs_addr=8, id_uses_rs=1 -> pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1 for one cycle; stall_cnt 0->1.
REQ-043 Same as REQ-042 but ex_write_addr=0 -> no stall; all wr_en=1.
REQ-044 ex_muldiv_start pulse, muldiv_done high 5 cycles later -> 5 stall cycles with all three wr_en=0; release on the done cycle; stall_cnt=5.
REQ-045 ex_branch_taken=1 and id_jump=1 together -> both flushes=1, wr_en all 1; flush_cnt +1.
REQ-046 MD_MAX=4, done never asserted -> stall 4 cycles, md_error=1, state RUN; then reset==0 -> md_error=0, counters 0.
REQ-047 Force stall_cnt to all-ones with CNT_W=4 (15 stall cycles) plus one more stall -> remains 15.
